// File: rtl/gas_pkg.sv
// Shared definitions for the gas/CO2 sequence alarm: alarm FSM encoding,
// default pattern and the hold-off counter width helper.
package gas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ALARM   = 2'd1,
    ST_HOLDOFF = 2'd2
  } alarm_st_e;

  localparam int              PAT_LEN_C     = 9;
  localparam logic [8:0]      DEFAULT_PAT_C = 9'b100100100;

  function automatic int holdoff_w(input int holdoff);
    return $clog2(holdoff + 1);
  endfunction

endpackage

// File: rtl/gas_seq_alarm_seq_matcher.sv
// Serial pattern matcher: shift history, fill tracking with overlap control,
// loadable pattern register and a registered one-cycle match pulse.
module seq_matcher
  import gas_pkg::*;
#(
  parameter int                 PAT_LEN     = 9,
  parameter logic [PAT_LEN-1:0] DEFAULT_PAT = DEFAULT_PAT_C
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               x,
  input  logic               x_valid,
  input  logic               overlap,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  output logic               hit_o,
  output logic               Z
);

  localparam int              FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0] hist_q;
  logic [PAT_LEN-1:0] hist_d;
  logic [PAT_LEN-1:0] pat_q;
  logic [FILL_W-1:0]  fill_q;
  logic [FILL_W-1:0]  fill_d;
  logic               z_q;
  logic               hit_s;

  // Post-shift history and fill; a hit is judged on these next-state values.
  always_comb begin
    hist_d = {hist_q[PAT_LEN-2:0], x};
    if (fill_q == FILL_FULL) begin
      fill_d = fill_q;
    end else begin
      fill_d = fill_q + FILL_W'(1);
    end
    hit_s = x_valid & ~pat_load & (fill_d == FILL_FULL) & (hist_d == pat_q);
  end

  // Matcher state; pattern load outranks sampling.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= DEFAULT_PAT;
      z_q    <= 1'b0;
    end else if (pat_load) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= pat_in;
      z_q    <= 1'b0;
    end else if (x_valid) begin
      hist_q <= hist_d;
      fill_q <= (hit_s && !overlap) ? '0 : fill_d;
      z_q    <= hit_s;
    end else begin
      z_q    <= 1'b0;
    end
  end

  assign hit_o = hit_s;
  assign Z     = z_q;

endmodule

// File: rtl/gas_seq_alarm.sv
// Gas/CO2 sequence alarm top: pattern matcher plus saturating hit counter,
// threshold compare and latched alarm with post-acknowledge hold-off.
module gas_seq_alarm
  import gas_pkg::*;
#(
  parameter int                 PAT_LEN     = 9,
  parameter logic [PAT_LEN-1:0] DEFAULT_PAT = DEFAULT_PAT_C,
  parameter int                 CNT_W       = 4,
  parameter int                 HOLDOFF     = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               x,
  input  logic               x_valid,
  input  logic               overlap,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic [CNT_W-1:0]   thresh,
  input  logic               ack,
  output logic               Z,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic               alarm,
  output logic               holdoff_act
);

  localparam int               HO_W    = holdoff_w(HOLDOFF);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  alarm_st_e          state_q;
  logic [CNT_W-1:0]   hit_cnt_q;
  logic               alarm_q;
  logic               holdoff_act_q;
  logic [HO_W-1:0]    ho_cnt_q;
  logic               hit_s;
  logic [CNT_W-1:0]   cnt_base_s;
  logic [CNT_W-1:0]   cnt_new_s;

  seq_matcher #(
    .PAT_LEN     (PAT_LEN),
    .DEFAULT_PAT (DEFAULT_PAT)
  ) u_matcher (
    .CLK      (CLK),
    .RST      (RST),
    .x        (x),
    .x_valid  (x_valid),
    .overlap  (overlap),
    .pat_load (pat_load),
    .pat_in   (pat_in),
    .hit_o    (hit_s),
    .Z        (Z)
  );

  // Acknowledge clears before the same-cycle hit is counted; hold-off freezes the count.
  always_comb begin
    if (ack && (state_q != ST_HOLDOFF)) begin
      cnt_base_s = '0;
    end else begin
      cnt_base_s = hit_cnt_q;
    end
    if (hit_s && (state_q != ST_HOLDOFF) && (cnt_base_s != CNT_MAX)) begin
      cnt_new_s = cnt_base_s + CNT_W'(1);
    end else begin
      cnt_new_s = cnt_base_s;
    end
  end

  // Alarm FSM with registered count, alarm and hold-off flags.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= ST_IDLE;
      hit_cnt_q     <= '0;
      alarm_q       <= 1'b0;
      holdoff_act_q <= 1'b0;
      ho_cnt_q      <= '0;
    end else if (pat_load) begin
      state_q       <= ST_IDLE;
      hit_cnt_q     <= '0;
      alarm_q       <= 1'b0;
      holdoff_act_q <= 1'b0;
      ho_cnt_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          hit_cnt_q <= cnt_new_s;
          if ((thresh != '0) && (cnt_new_s >= thresh)) begin
            state_q <= ST_ALARM;
            alarm_q <= 1'b1;
          end
        end
        ST_ALARM: begin
          hit_cnt_q <= cnt_new_s;
          if (ack) begin
            state_q       <= ST_HOLDOFF;
            alarm_q       <= 1'b0;
            holdoff_act_q <= 1'b1;
            ho_cnt_q      <= HO_W'(HOLDOFF);
          end
        end
        ST_HOLDOFF: begin
          if (x_valid) begin
            if ((ho_cnt_q == HO_W'(1)) || (ho_cnt_q == '0)) begin
              state_q       <= ST_IDLE;
              holdoff_act_q <= 1'b0;
              ho_cnt_q      <= '0;
            end else begin
              ho_cnt_q <= ho_cnt_q - HO_W'(1);
            end
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          alarm_q       <= 1'b0;
          holdoff_act_q <= 1'b0;
          ho_cnt_q      <= '0;
        end
      endcase
    end
  end

  assign hit_cnt     = hit_cnt_q;
  assign alarm       = alarm_q;
  assign holdoff_act = holdoff_act_q;

endmodule

// File: doc/gas_seq_alarm.md
Name: gas_seq_alarm

Overview:
Next-generation serial sensor-pattern detector for the smart-home gas/CO2 channel. It compares the most recent PAT_LEN sampled sensor bits against a run-time loadable pattern and emits a one-cycle match pulse on each hit. It counts hits, raises a latched alarm at a programmable threshold, and applies a hold-off after acknowledge. It sits between the sensor bit sampler and the home controller's alarm/interrupt logic.

Parameters:
PAT_LEN, 9, pattern length in bits (2..32)
DEFAULT_PAT, 9'b100100100, pattern register reset value (PAT_LEN bits; MSB = oldest bit)
CNT_W, 4, hit counter width
HOLDOFF, 8, valid samples after ack during which hits are not counted (1..255)

Ports:
CLK  in  1  clock
RST  in  1  reset
x  in  1  sensor bit
x_valid  in  1  sample strobe; x is taken only when high
overlap  in  1  1 = overlapping matches, 0 = non-overlapping
pat_load  in  1  load pat_in into the pattern register
pat_in  in  PAT_LEN  new pattern
thresh  in  CNT_W  alarm threshold; 0 = alarm disabled
ack  in  1  alarm acknowledge / counter clear
Z  out  1  match pulse, one cycle
hit_cnt  out  CNT_W  saturating hit count
alarm  out  1  latched alarm
holdoff_act  out  1  high while in HOLDOFF

Behaviour:
- Reset: RST is asynchronous, active-low; CLK is the clock. On reset: hist=0, fill=0, pat=DEFAULT_PAT, Z=0, hit_cnt=0, alarm=0, holdoff_act=0, FSM=IDLE, holdoff counter=0.
- Sampling (x_valid=1, pat_load=0):
  - hist <= {hist[PAT_LEN-2:0], x}.
  - fill increments, saturating at PAT_LEN.
- Match: hit = x_valid & (fill_next==PAT_LEN) & (hist_next==pat). The comparison uses post-shift values.
  - Z is registered and goes high in the cycle after the sampling edge, for exactly one cycle per hit.
  - Back-to-back valid samples can give Z high on consecutive cycles, each a separate hit.
- Overlap mode:
  - overlap=1: fill stays at PAT_LEN after a hit, so the next bit can complete a new match.
  - overlap=0: on a hit, fill is cleared to 0 and hist keeps shifting. A full PAT_LEN new bits are required before the next hit.
  - overlap is sampled on each valid sample; changing it mid-stream takes effect on the next hit.
- x_valid=0: nothing shifts and no hit occurs. Z is 0.
- pat_load (highest priority, synchronous):
  - pat <= pat_in; hist, fill and hit_cnt are cleared.
  - FSM goes to IDLE, alarm=0, Z=0 next cycle.
  - x_valid in the same cycle is ignored.
- Counting:
  - A hit increments hit_cnt only in IDLE or ALARM, not in HOLDOFF.
  - hit_cnt saturates at 2^CNT_W-1.
  - ack in IDLE: clears hit_cnt; no hold-off.
  - ack together with a hit (IDLE or ALARM): clear first, then count, so hit_cnt=1.
- Alarm FSM:
  - IDLE: alarm=0. Go to ALARM when thresh!=0 and the updated hit_cnt >= thresh; alarm rises the cycle after the triggering hit, aligned with Z.
  - ALARM: alarm=1, held until ack. On ack: alarm=0, hit_cnt cleared (or set to 1 if a hit occurs in the same cycle, per Counting rule), holdoff counter loaded with HOLDOFF, go to HOLDOFF. Hits in ALARM keep counting.
  - HOLDOFF: holdoff_act=1. Each valid sample decrements the counter. When it reaches 0, go to IDLE. Hits still pulse Z but do not count. ack is ignored.
- Raising thresh to above hit_cnt while in ALARM does not clear alarm; only ack or pat_load clears it.
- Asynchronous reset mid-operation returns all state to reset values immediately.

Decomposition:
- Shared package gas_pkg:
  - alarm FSM state encoding (IDLE=2'd0, ALARM=2'd1, HOLDOFF=2'd2)
  - default pattern constant
  - width helper for the holdoff counter, $clog2(HOLDOFF+1)
- One natural sub-module, seq_matcher. It holds hist, fill, pat, the overlap logic and the registered Z. The top level holds the counter, threshold compare and alarm FSM.

Test Plan:
- Defaults, overlap=1, thresh=0; valid stream 100100100 then 100 -> Z pulses after bit 9 and after bit 12; hit_cnt=2; alarm stays 0.
- Same stream with overlap=0 -> only one Z pulse (after bit 9); the second needs 9 further bits; hit_cnt=1.
- Load pat_in=9'b111000111, thresh=2, stream it twice with overlap=0 -> second Z and alarm=1 in the same cycle; hit_cnt=2.
- In ALARM, pulse ack together with a hit -> alarm=0, hit_cnt=1, holdoff_act=1.
- Hits during HOLDOFF pulse Z without counting; after 8 valid samples holdoff_act=0 and state is IDLE.
- Stream with x_valid gaps (x toggling while invalid), then CNT_W=4 saturation at 15, then async RST low mid-stream -> invalid bits ignored; saturation holds at 15; reset clears all outputs and restores pat=100100100.
